// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, reset vector, the NOP
// encoding and the major opcodes seen by the control unit.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // addi x0, x0, 0 -- shown to decode whenever no fetched word is available
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of {pc, instr} entries between the memory response path and
// decode. The head entry is held in its own register so it is stable while empty.
module fetch_fifo #(
    parameter int               DEPTH      = 2,
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] HEAD_RESET = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [WIDTH-1:0]             o_head
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_do_pop;
    logic             w_do_push;
    logic [CW-1:0]    w_remain;
    logic [PW-1:0]    w_rd_next;
    logic [WIDTH-1:0] w_head_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);
    assign w_remain  = r_count - CW'(w_do_pop);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_rd_next   = w_do_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        w_head_next = r_head;
        if (w_remain != '0) begin
            w_head_next = r_mem[w_rd_next];
        end else if (w_do_push) begin
            w_head_next = i_push_data;
        end
    end

    // NOTE: the storage array has no reset; r_count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= HEAD_RESET;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_do_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
            r_rd_ptr <= w_rd_next;
            r_count  <= w_remain + CW'(w_do_push);
            r_head   <= w_head_next;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_head;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited requests to
// instruction memory, stale-response dropping after redirects, decode FIFO.
module instr_fetch_unit #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [6:0]      if_opcode
);

    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic            w_credit_ok;
    logic            w_accept;
    logic            w_resp_seen;
    logic            w_resp_drop;
    logic            w_resp_live;
    logic [XLEN-1:0] w_target;
    logic [CW-1:0]   w_out_live;
    logic [CW-1:0]   w_out_next;
    logic [CW-1:0]   w_drop_next;
    logic [CW-1:0]   w_fifo_count;
    logic [2*XLEN-1:0] w_fifo_head;
    logic [1:0]      w_unused_redirect_lsb;

    // Everything in flight, waiting to be dropped, or buffered shares one budget of DEPTH.
    assign w_credit_ok = (SW'(r_outstanding) + SW'(r_drop_cnt) + SW'(w_fifo_count)) < SW'(DEPTH);

    assign imem_req_valid = (r_state == ST_RUN) && w_credit_ok && !redirect_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    // Responses with no matching request are ignored rather than trusted.
    assign w_resp_seen = imem_resp_valid && !reset;
    assign w_resp_drop = w_resp_seen && (r_drop_cnt != '0);
    assign w_resp_live = w_resp_seen && (r_drop_cnt == '0) && (r_outstanding != '0);

    assign w_target              = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused_redirect_lsb = redirect_pc[1:0];

    always_comb begin
        w_out_live  = r_outstanding + CW'(w_accept) - CW'(w_resp_live);
        w_out_next  = w_out_live;
        w_drop_next = r_drop_cnt - CW'(w_resp_drop);
        if (redirect_valid) begin
            w_out_next  = '0;
            w_drop_next = r_drop_cnt - CW'(w_resp_drop) + w_out_live;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_state       <= ST_RUN;
            r_outstanding <= w_out_next;
            r_drop_cnt    <= w_drop_next;
            if (redirect_valid) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (w_resp_live) begin
                    r_resp_pc <= r_resp_pc + XLEN'(4);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH      (DEPTH),
        .WIDTH      (2 * XLEN),
        .HEAD_RESET ({{XLEN{1'b0}}, XLEN'(NOP_INSTR)})
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_resp_live && !redirect_valid),
        .i_push_data ({r_resp_pc, imem_resp_data}),
        .i_pop       (if_ready),
        .i_flush     (redirect_valid),
        .o_count     (w_fifo_count),
        .o_head      (w_fifo_head)
    );

    assign if_valid  = (w_fifo_count != '0);
    assign if_pc     = w_fifo_head[2*XLEN-1:XLEN];
    assign if_instr  = if_valid ? w_fifo_head[XLEN-1:0] : XLEN'(NOP_INSTR);
    assign if_opcode = if_instr[6:0];

    a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
        !(imem_resp_valid && (r_outstanding == '0) && (r_drop_cnt == '0)));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a one-cycle-latency memory model feeds
// responses, and a linear sequence of steps checks hand-computed outputs.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data  = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] acc_q[$];
    bit          resp_en;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .if_opcode       (if_opcode)
    );

    // Instruction memory contents: two fixed words, otherwise {addr[24:0], OP_IMM}.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0033;
        if (a == 32'h4) return 32'h0000_2003;
        return {a[24:0], 7'b0010011};
    endfunction

    always @(posedge clk) begin
        if (!reset && imem_req_valid && imem_req_ready) acc_q.push_back(imem_req_addr);
    end

    always @(negedge clk) begin
        if (reset) begin
            acc_q.delete();
            imem_resp_valid = 1'b0;
        end else if (resp_en && acc_q.size() > 0) begin
            imem_resp_data  = mem_word(acc_q.pop_front());
            imem_resp_valid = 1'b1;
        end else begin
            imem_resp_valid = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        resp_en        = 1'b1;
        repeat (3) step();
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_req_addr",  imem_req_addr,       32'h0);
        check("rst_if_valid",  32'(if_valid),       32'h0);
        check("rst_if_pc",     if_pc,               32'h0);
        check("rst_if_instr",  if_instr,            32'h0000_0013);
        check("rst_if_opcode", 32'(if_opcode),      32'h13);

        // Reset release: IDLE for one cycle, then sequential fetches.
        reset = 1'b0;
        check("idle_no_req", 32'(imem_req_valid), 32'h0);
        step();
        check("req0_valid", 32'(imem_req_valid), 32'h1);
        check("req0_addr",  imem_req_addr,       32'h0);
        step();
        check("req1_addr",  imem_req_addr,       32'h4);
        check("early_if_valid", 32'(if_valid),   32'h0);
        step();
        check("first_if_valid", 32'(if_valid),   32'h1);
        check("first_if_pc",    if_pc,           32'h0);
        check("first_opcode",   32'(if_opcode),  32'b0110011);
        check("credit_full",    32'(imem_req_valid), 32'h0);
        step();
        check("second_if_pc",   if_pc,           32'h4);
        check("second_opcode",  32'(if_opcode),  32'b0000011);
        check("req2_addr",      imem_req_addr,   32'h8);
        step();
        check("empty_if_valid", 32'(if_valid),   32'h0);
        check("empty_nop",      if_instr,        32'h0000_0013);
        check("empty_pc_hold",  if_pc,           32'h4);
        check("req3_addr",      imem_req_addr,   32'hC);

        // Decode stall: FIFO fills to DEPTH and fetching stops.
        if_ready = 1'b0;
        repeat (10) step();
        check("stall_if_valid", 32'(if_valid),       32'h1);
        check("stall_no_req",   32'(imem_req_valid), 32'h0);
        check("stall_head_pc",  if_pc,               32'h8);
        check("stall_head_ins", if_instr,            32'h0000_0413);
        if_ready = 1'b1;
        step();
        check("resume_pc",    if_pc,    32'hC);
        check("resume_instr", if_instr, 32'h0000_0613);
        imem_req_ready = 1'b0;
        step();
        check("resume_drained", 32'(if_valid),   32'h0);
        check("held_req_valid", 32'(imem_req_valid), 32'h1);
        check("held_req_addr",  imem_req_addr,   32'h10);

        // Redirect with two requests outstanding.
        resp_en        = 1'b0;
        imem_req_ready = 1'b1;
        step();
        check("rd1_req_addr", imem_req_addr, 32'h14);
        step();
        check("rd1_two_out", 32'(imem_req_valid), 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        resp_en        = 1'b1;
        check("rd1_drop_credit", 32'(imem_req_valid), 32'h0);
        step();
        check("rd1_drop0_if", 32'(if_valid),   32'h0);
        check("rd1_tgt_addr", imem_req_addr,   32'h100);
        step();
        check("rd1_drop1_if", 32'(if_valid),   32'h0);
        check("rd1_next_addr", imem_req_addr,  32'h104);
        step();
        check("rd1_if_valid", 32'(if_valid),   32'h1);
        check("rd1_if_pc",    if_pc,           32'h100);
        check("rd1_if_instr", if_instr,        32'h0000_8013);
        imem_req_ready = 1'b0;
        step();
        check("rd1_if_pc2",   if_pc,           32'h104);
        check("rd1_if_instr2", if_instr,       32'h0000_8213);
        step();
        check("rd2_held_addr", imem_req_addr,  32'h108);

        // Redirect in the same cycle as a live response, with a second request in flight.
        imem_req_ready = 1'b1;
        resp_en        = 1'b0;
        step();
        check("rd2_req_addr", imem_req_addr, 32'h10C);
        step();
        check("rd2_two_out", 32'(imem_req_valid), 32'h0);
        resp_en        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h202;
        step();
        redirect_valid = 1'b0;
        check("rd2_tgt_addr",  imem_req_addr,   32'h200);
        check("rd2_no_stale",  32'(if_valid),   32'h0);
        step();
        check("rd2_drop_done", 32'(imem_req_valid), 32'h1);
        check("rd2_next_addr", imem_req_addr,   32'h204);
        check("rd2_no_stale2", 32'(if_valid),   32'h0);
        step();
        check("rd2_if_pc",    if_pc,    32'h200);
        check("rd2_if_instr", if_instr, 32'h0001_0013);

        // Unaligned redirect near the top of memory, then PC wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        check("wrap_flushed", 32'(if_valid),   32'h0);
        check("wrap_addr0",   imem_req_addr,   32'hFFFF_FFFC);
        step();
        check("wrap_addr1",   imem_req_addr,   32'h0);
        step();
        check("wrap_if_pc0",  if_pc,           32'hFFFF_FFFC);
        check("wrap_instr0",  if_instr,        32'hFFFF_FE13);
        step();
        check("wrap_if_pc1",  if_pc,           32'h0);
        check("wrap_opcode1", 32'(if_opcode),  32'b0110011);

        // Reset mid-stream.
        reset = 1'b1;
        step();
        check("mrst_if_valid",  32'(if_valid),       32'h0);
        check("mrst_req_valid", 32'(imem_req_valid), 32'h0);
        check("mrst_req_addr",  imem_req_addr,       32'h0);
        check("mrst_if_pc",     if_pc,               32'h0);
        check("mrst_if_instr",  if_instr,            32'h0000_0013);
        reset = 1'b0;
        step();
        check("mrst_restart_v", 32'(imem_req_valid), 32'h1);
        check("mrst_restart_a", imem_req_addr,       32'h0);
        step();
        step();
        check("mrst_if_valid2", 32'(if_valid),  32'h1);
        check("mrst_if_pc2",    if_pc,          32'h0);
        check("mrst_if_instr2", if_instr,       32'h0000_0033);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
